// File: rtl/iccm_loader_pkg.sv
// ============================================================================
//  buraq_loader_pkg
//  Shared state encoding and byte-packing constants for the ICCM loader.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package buraq_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_CHECK = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } ldr_state_t;

endpackage

`default_nettype wire

// File: rtl/iccm_loader_if.sv
// ============================================================================
//  iccm_loader_if
//  Byte-stream input, ICCM write port and core status bundle for the loader.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface iccm_loader_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 15
);
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 rx_ready;
    logic                 iccm_write;
    logic [AddrWidth-1:0] iccm_address;
    logic [DataWidth-1:0] iccm_data;
    logic                 core_rst;
    logic                 load_done;
    logic                 load_error;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, iccm_write, iccm_address, iccm_data,
        input  core_rst, load_done, load_error
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, iccm_write, iccm_address, iccm_data,
        output core_rst, load_done, load_error
    );
endinterface

`default_nettype wire

// File: rtl/ldr_word_packer.sv
// ============================================================================
//  ldr_word_packer
//  Little-endian byte-to-word shift register with a wrapping byte counter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ldr_word_packer
    import buraq_loader_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 shift_en,
    input  wire logic [7:0]           byte_in,
    output logic      [DataWidth-1:0] word,
    output logic                      word_full
);
    localparam int c_cnt_w = $clog2(BYTES_PER_WORD);

    logic [DataWidth-1:0] r_word;
    logic [c_cnt_w-1:0]   r_count;

    // New bytes enter at the top so the first byte ends up in bits 7:0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (shift_en) begin
            r_word  <= {byte_in, r_word[DataWidth-1:8]};
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    assign word      = r_word;
    assign word_full = shift_en && (r_count == c_cnt_w'(BYTES_PER_WORD - 1));

endmodule

`default_nettype wire

// File: rtl/iccm_loader.sv
// ============================================================================
//  iccm_loader
//  Receives a length-prefixed byte image and writes it word-by-word into ICCM.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module iccm_loader
    import buraq_loader_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 15
) (
    input  wire logic brq_clk,
    input  wire logic brq_rst,
    iccm_loader_if.slave bus
);
    localparam logic [DataWidth-1:0] c_depth = DataWidth'(1) << AddrWidth;

    ldr_state_t           r_state;
    ldr_state_t           w_state_next;
    logic [AddrWidth:0]   r_idx;
    logic [AddrWidth:0]   r_n;
    logic                 w_accept;
    logic                 w_word_full;
    logic [DataWidth-1:0] w_word;

    assign w_accept = bus.rx_valid & bus.rx_ready;

    ldr_word_packer #(
        .DataWidth (DataWidth)
    ) u_packer (
        .clk       (brq_clk),
        .rst       (brq_rst),
        .shift_en  (w_accept),
        .byte_in   (bus.rx_data),
        .word      (w_word),
        .word_full (w_word_full)
    );

    // The packer still holds the header during CHECK; latch N before payload overwrites it.
    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            r_state <= ST_HDR;
            r_idx   <= '0;
            r_n     <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_CHECK) begin
                r_idx <= '0;
                r_n   <= w_word[AddrWidth:0];
            end else if (r_state == ST_WRITE && w_state_next == ST_LOAD) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        bus.rx_ready   = 1'b0;
        bus.iccm_write = 1'b0;
        bus.core_rst   = 1'b1;
        bus.load_done  = 1'b0;
        bus.load_error = 1'b0;

        case (r_state)
            ST_HDR:   if (w_word_full) w_state_next = ST_CHECK;
            ST_CHECK: begin
                if (w_word == '0)          w_state_next = ST_DONE;
                else if (w_word > c_depth) w_state_next = ST_ERR;
                else                       w_state_next = ST_LOAD;
            end
            ST_LOAD:  if (w_word_full) w_state_next = ST_WRITE;
            ST_WRITE: begin
                if (r_idx + 1'b1 == r_n) w_state_next = ST_DONE;
                else                     w_state_next = ST_LOAD;
            end
            default:  w_state_next = r_state;
        endcase

        // Outputs are masked during the reset cycle, even if the old state was WRITE or DONE.
        if (!brq_rst) begin
            bus.rx_ready   = (r_state == ST_HDR) || (r_state == ST_LOAD);
            bus.iccm_write = (r_state == ST_WRITE);
            bus.core_rst   = (r_state != ST_DONE);
            bus.load_done  = (r_state == ST_DONE);
            bus.load_error = (r_state == ST_ERR);
        end
    end

    assign bus.iccm_address = r_idx[AddrWidth-1:0];
    assign bus.iccm_data    = w_word;

endmodule

`default_nettype wire

// File: doc/iccm_loader.md
ICCM_LOADER -- requirements
Module: iccm_loader

Interface
REQ-001 SHALL have parameter DataWidth, default 32: instruction word width (fixed at 32).
REQ-002 SHALL have parameter AddrWidth, default 15: ICCM word-index width; depth = 2**AddrWidth words.
REQ-003 SHALL have port brq_clk  input  1: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port brq_rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port rx_valid  input  1: a byte is offered on rx_data.
REQ-006 SHALL have port rx_data  input  8: byte-stream payload.
REQ-007 SHALL have port rx_ready  output  1: the loader accepts the byte this cycle.
REQ-008 SHALL have port iccm_write  output  1: one-cycle ICCM write strobe.
REQ-009 SHALL have port iccm_address  output  AddrWidth: ICCM word index.
REQ-010 SHALL have port iccm_data  output  DataWidth: instruction word to write.
REQ-011 SHALL have port core_rst  output  1: holds the core in reset until the load completes.
REQ-012 SHALL have port load_done  output  1: image fully written.
REQ-013 SHALL have port load_error  output  1: header word count exceeds ICCM depth.

Function
REQ-014 SHALL accept a byte only on a cycle where rx_valid and rx_ready are both 1; rx_data is otherwise ignored.
REQ-015 SHALL treat the stream as: 4-byte little-endian header N (word count), then 4*N bytes forming N little-endian words (first byte = bits 7:0).
REQ-016 SHALL implement states HDR, CHECK, LOAD, WRITE, DONE and ERR.
REQ-017 SHALL hold rx_ready at 1 only in HDR and LOAD.
REQ-018 HDR: SHALL shift in header bytes; after the 4th accepted byte it SHALL go to CHECK.
REQ-019 CHECK (one cycle): N==0 SHALL go to DONE; N > 2**AddrWidth SHALL go to ERR; otherwise SHALL go to LOAD with word index 0.
REQ-020 LOAD: SHALL pack bytes with a 2-bit byte counter; after the 4th byte it SHALL go to WRITE.
REQ-021 WRITE: SHALL assert iccm_write for exactly 1 cycle with iccm_address = word index and iccm_data = packed word. This cycle is the one immediately after the 4th byte is accepted.
REQ-022 After WRITE: if word index + 1 == N it SHALL go to DONE, else SHALL increment the word index and return to LOAD.
REQ-023 The word-index compare SHALL use AddrWidth+1 bits so that N == 2**AddrWidth completes without wrap-around.
REQ-024 DONE and ERR SHALL be terminal until brq_rst; bytes offered in these states SHALL NOT be accepted.
REQ-025 iccm_write SHALL be 0 outside WRITE; iccm_address and iccm_data MAY hold stale values when iccm_write is 0.
REQ-026 core_rst SHALL be 1 in every state except DONE; load_done SHALL be 1 only in DONE; load_error SHALL be 1 only in ERR.
REQ-027 Stalls (rx_valid low) SHALL be allowed at any byte boundary with no loss or duplication of bytes.

Reset
REQ-028 brq_rst SHALL synchronously force HDR and clear the byte counter, word index and header register.
REQ-029 Reset values SHALL be: rx_ready 0 during the reset cycle then 1, iccm_write 0, core_rst 1, load_done 0, load_error 0.
REQ-030 brq_rst asserted mid-load, including in WRITE, SHALL abort the load; no iccm_write SHALL occur in the reset cycle.

Structure
REQ-031 A shared package buraq_loader_pkg SHALL hold the state enum and the BYTES_PER_WORD=4 constant.
REQ-032 Byte-to-word packing SHALL be a sub-module ldr_word_packer (shift register plus byte counter), reused for both header and payload.

Verification
REQ-033 Header 02 00 00 00, then bytes 13 00 00 00 B3 00 10 00 -> writes (addr 0, 0x00000013) then (addr 1, 0x001000B3); load_done=1; core_rst falls the cycle after the second write.
REQ-034 Header 00 00 00 00 -> no iccm_write; DONE two cycles after the 4th byte; core_rst=0.
REQ-035 Header 01 80 00 00 (N=32769 > 32768) -> ERR; load_error=1, core_rst stays 1, rx_ready=0, no writes.
REQ-036 N=1, payload bytes separated by random rx_valid gaps of 0-5 cycles -> a single write of the correct word exactly one cycle after the last byte.
REQ-037 brq_rst pulsed after 2 payload bytes, then a clean N=1 image 6F 00 00 00 -> single write (addr 0, 0x0000006F); no write from the aborted load.
REQ-038 Bytes offered after DONE -> rx_ready=0, no further writes, outputs unchanged.
